// File: rtl/tile_board_engine.sv
// Tile board engine: six-line scrolling tile board plus a 120x120 renderer
// that streams one pixel per cycle from a snapshot of the board.
// Optional build macro TILE_SEPARATOR_EN draws 3'b001 lane separators at
// x=39 and x=79. Without the macro no separator logic is built.
//
// state | meaning
// IDLE  | waiting for draw_go; board may change freely
// DRAW  | sweeping pixels (0,0)..(119,119), plot=1 every cycle
// DONE  | sweep finished, draw_done=1 until draw_go drops
module tile_board_engine (
  input  logic       clock,
  input  logic       resetn,
  input  logic       board_clear,
  input  logic       draw_go,
  input  logic       edge_go,
  input  logic       offset_increase,
  output logic       draw_done,
  output logic [5:0] offset,
  output logic [2:0] line_6,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  localparam logic [7:0] LAST_COORD = 8'd119;
  localparam logic [5:0] OFFSET_MAX = 6'd40;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;
  logic [2:0] w_new_row;
  logic [2:0] r_line_1, r_line_2, r_line_3, r_line_4, r_line_5, r_line_6;
  logic [5:0] r_offset;

  // Lines 1 and 2 can never be reached by the row mapping (ye <= 159), so
  // only lines 3..6 are kept in the snapshot.
  logic [5:0] r_snap_offset;
  logic [2:0] r_snap_3, r_snap_4, r_snap_5, r_snap_6;

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_done;

  logic [7:0] w_x_next;
  logic [6:0] w_y_next;
  logic [2:0] w_colour_next;
  logic       w_plot_next;
  logic       w_done_next;
  logic       w_snap_load;

  logic [7:0] w_nx;
  logic [6:0] w_ny;
  logic [5:0] w_src_offset;
  logic [2:0] w_src_3, w_src_4, w_src_5, w_src_6;
  logic [7:0] w_ye;
  logic [2:0] w_row;
  logic       w_hit;
  logic [2:0] w_pix_colour;

  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Row pattern injected at the top on each edge_go.
  always_comb begin
    w_new_row = 3'b000;
    case (r_lfsr[1:0])
      2'd0:    w_new_row = 3'b001;
      2'd1:    w_new_row = 3'b010;
      2'd2:    w_new_row = 3'b100;
      default: w_new_row = 3'b000;
    endcase
  end

  // Free-running LFSR; board_clear deliberately leaves it alone.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_lfsr <= 8'hA5;
    else         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  // Live board: clear beats shift, shift beats offset advance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_line_1 <= 3'b000;
      r_line_2 <= 3'b000;
      r_line_3 <= 3'b000;
      r_line_4 <= 3'b000;
      r_line_5 <= 3'b000;
      r_line_6 <= 3'b000;
      r_offset <= 6'd0;
    end else if (board_clear) begin
      r_line_1 <= 3'b000;
      r_line_2 <= 3'b000;
      r_line_3 <= 3'b000;
      r_line_4 <= 3'b000;
      r_line_5 <= 3'b000;
      r_line_6 <= 3'b000;
      r_offset <= 6'd0;
    end else if (edge_go) begin
      r_line_6 <= r_line_5;
      r_line_5 <= r_line_4;
      r_line_4 <= r_line_3;
      r_line_3 <= r_line_2;
      r_line_2 <= r_line_1;
      r_line_1 <= w_new_row;
      r_offset <= 6'd0;
    end else if (offset_increase && (r_offset < OFFSET_MAX)) begin
      r_offset <= r_offset + 6'd1;
    end
  end

  // Coordinates of the pixel to be registered at the next edge.
  always_comb begin
    w_nx = 8'd0;
    w_ny = 7'd0;
    if (r_state == S_DRAW) begin
      if (r_x == LAST_COORD) begin
        w_nx = 8'd0;
        w_ny = r_y + 7'd1;
      end else begin
        w_nx = r_x + 8'd1;
        w_ny = r_y;
      end
    end
  end

  // The first pixel is rendered while the snapshot is being loaded, so it
  // reads the live board; every later pixel reads the snapshot.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_src_offset = r_offset;
      w_src_3      = r_line_3;
      w_src_4      = r_line_4;
      w_src_5      = r_line_5;
      w_src_6      = r_line_6;
    end else begin
      w_src_offset = r_snap_offset;
      w_src_3      = r_snap_3;
      w_src_4      = r_snap_4;
      w_src_5      = r_snap_5;
      w_src_6      = r_snap_6;
    end
  end

  // Pixel colour lookup: pick the board line from the scrolled row, then the lane bit.
  always_comb begin
    w_ye = {1'b0, w_ny} + 8'd40 - {2'b00, w_src_offset};
    if (w_ye < 8'd40)       w_row = w_src_3;
    else if (w_ye < 8'd80)  w_row = w_src_4;
    else if (w_ye < 8'd120) w_row = w_src_5;
    else                    w_row = w_src_6;
    if (w_nx < 8'd40)       w_hit = w_row[0];
    else if (w_nx < 8'd80)  w_hit = w_row[1];
    else                    w_hit = w_row[2];
    w_pix_colour = w_hit ? 3'b000 : 3'b111;
`ifdef TILE_SEPARATOR_EN
    if ((w_nx == 8'd39) || (w_nx == 8'd79)) w_pix_colour = 3'b001;
`endif
  end

  // Renderer next-state and next-output decode.
  always_comb begin
    w_state_next  = r_state;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_colour_next = r_colour;
    w_plot_next   = 1'b0;
    w_done_next   = 1'b0;
    w_snap_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (draw_go) begin
          w_state_next  = S_DRAW;
          w_snap_load   = 1'b1;
          w_x_next      = w_nx;
          w_y_next      = w_ny;
          w_colour_next = w_pix_colour;
          w_plot_next   = 1'b1;
        end
      end
      S_DRAW: begin
        if ((r_x == LAST_COORD) && (r_y == LAST_COORD[6:0])) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_x_next      = w_nx;
          w_y_next      = w_ny;
          w_colour_next = w_pix_colour;
          w_plot_next   = 1'b1;
        end
      end
      S_DONE: begin
        if (draw_go) w_done_next  = 1'b1;
        else         w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Renderer state, registered pixel outputs and board snapshot.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_x           <= 8'd0;
      r_y           <= 7'd0;
      r_colour      <= 3'b000;
      r_plot        <= 1'b0;
      r_done        <= 1'b0;
      r_snap_offset <= 6'd0;
      r_snap_3      <= 3'b000;
      r_snap_4      <= 3'b000;
      r_snap_5      <= 3'b000;
      r_snap_6      <= 3'b000;
    end else begin
      r_state  <= w_state_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_colour <= w_colour_next;
      r_plot   <= w_plot_next;
      r_done   <= w_done_next;
      if (w_snap_load) begin
        r_snap_offset <= r_offset;
        r_snap_3      <= r_line_3;
        r_snap_4      <= r_line_4;
        r_snap_5      <= r_line_5;
        r_snap_6      <= r_line_6;
      end
    end
  end

  assign draw_done = r_done;
  assign offset    = r_offset;
  assign line_6    = r_line_6;
  assign x         = r_x;
  assign y         = r_y;
  assign colour    = r_colour;
  assign plot      = r_plot;

endmodule

// File: tb/tb_tile_board_engine.sv
// Bench for tile_board_engine: board/scroll model plus per-pixel render model.
module tb_tile_board_engine;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       board_clear = 1'b0;
  logic       draw_go = 1'b0;
  logic       edge_go = 1'b0;
  logic       offset_increase = 1'b0;
  logic       draw_done;
  logic [5:0] offset;
  logic [2:0] line_6;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  int errors = 0;
  int checks = 0;

  tile_board_engine dut (
    .clock(clock), .resetn(resetn), .board_clear(board_clear),
    .draw_go(draw_go), .edge_go(edge_go), .offset_increase(offset_increase),
    .draw_done(draw_done), .offset(offset), .line_6(line_6),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference board: lines indexed 1 (top) .. 6 (bottom).
  logic [7:0] m_lfsr;
  logic [2:0] m_line [1:6];
  int         m_off;

  function automatic logic [2:0] row_of(input logic [7:0] l);
    int c;
    c = int'(l[1:0]);
    if (c == 3) return 3'b000;
    return 3'(1 << c);
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_lfsr = 8'hA5;
      foreach (m_line[i]) m_line[i] = 3'b000;
      m_off = 0;
    end else begin
      if (board_clear) begin
        foreach (m_line[i]) m_line[i] = 3'b000;
        m_off = 0;
      end else if (edge_go) begin
        for (int i = 6; i > 1; i--) m_line[i] = m_line[i-1];
        m_line[1] = row_of(m_lfsr);
        m_off = 0;
      end else if (offset_increase) begin
        m_off = (m_off < 40) ? m_off + 1 : 40;
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  function automatic logic [2:0] pix(input int px, input int py, input int off,
                                     input logic [2:0] l3, input logic [2:0] l4,
                                     input logic [2:0] l5, input logic [2:0] l6);
    int ye, band, lane;
    logic [2:0] row;
    ye   = (py + 40 - off) % 256;
    band = ye / 40;
    case (band)
      0:       row = l3;
      1:       row = l4;
      2:       row = l5;
      default: row = l6;
    endcase
    lane = px / 40;
`ifdef TILE_SEPARATOR_EN
    if (px == 39 || px == 79) return 3'b001;
`endif
    return row[lane] ? 3'b000 : 3'b111;
  endfunction

  // Full sweep against the snapshot model; optional mid-sweep board churn
  // and draw_go drop, optional reset at pixel abort_at.
  task automatic run_sweep(input string nm, input bit churn, input int abort_at);
    logic [2:0] s3, s4, s5, s6, ec;
    int soff, bad, plots, ex, ey;
    string first_bad;
    bad = 0; plots = 0; first_bad = "";
    @(negedge clock);
    edge_go = 0; offset_increase = 0; board_clear = 0; draw_go = 1;
    soff = m_off; s3 = m_line[3]; s4 = m_line[4]; s5 = m_line[5]; s6 = m_line[6];
    for (int i = 0; i < 14400; i++) begin
      ex = i % 120; ey = i / 120;
      ec = pix(ex, ey, soff, s3, s4, s5, s6);
      @(negedge clock);
      if (plot === 1'b1) plots++;
      if (i == 0) begin
        checks++;
        if (plot !== 1'b1 || x !== 8'd0 || y !== 7'd0) begin
          errors++;
          $display("FAIL %s_first_pixel: got plot=%0b x=%0d y=%0d want plot=1 x=0 y=0", nm, plot, x, y);
        end
      end
      if (i == 14399) begin
        checks++;
        if (x !== 8'd119 || y !== 7'd119) begin
          errors++;
          $display("FAIL %s_last_pixel: got x=%0d y=%0d want x=119 y=119", nm, x, y);
        end
      end
      if (plot !== 1'b1 || x !== 8'(ex) || y !== 7'(ey) || colour !== ec) begin
        if (bad == 0)
          first_bad = $sformatf("i=%0d got plot=%0b x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                                i, plot, x, y, colour, ex, ey, ec);
        bad++;
      end
      if (i == abort_at) begin
        resetn = 0;
        #1;
        checks++;
        if (plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || draw_done !== 1'b0) begin
          errors++;
          $display("FAIL %s_reset_abort: got plot=%0b x=%0d y=%0d done=%0b want 0 0 0 0",
                   nm, plot, x, y, draw_done);
        end
        draw_go = 0; edge_go = 0; offset_increase = 0;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL %s_pixels: %0d bad, first %s", nm, bad, first_bad);
        end
        return;
      end
      if (churn) begin
        edge_go = (i % 1500 == 700);
        offset_increase = ($urandom_range(0, 99) < 3);
        if (i == 100) draw_go = 0;
      end
    end
    edge_go = 0; offset_increase = 0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_pixels: %0d bad, first %s", nm, bad, first_bad);
    end
    checks++;
    if (plots != 14400) begin
      errors++;
      $display("FAIL %s_plot_count: got %0d want 14400", nm, plots);
    end
    @(negedge clock);
    checks++;
    if (plot !== 1'b0 || draw_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_entry: got plot=%0b done=%0b want plot=0 done=1", nm, plot, draw_done);
    end
  endtask

  task automatic test_reset;
    resetn = 0;
    repeat (3) @(negedge clock);
    resetn = 1;
    @(negedge clock);
    checks++;
    if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %0b want 0", plot); end
    checks++;
    if (draw_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", draw_done); end
    checks++;
    if (x !== 8'd0 || y !== 7'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); end
    checks++;
    if (colour !== 3'b000) begin errors++; $display("FAIL reset_colour: got %0d want 0", colour); end
    checks++;
    if (offset !== 6'd0) begin errors++; $display("FAIL reset_offset: got %0d want 0", offset); end
    checks++;
    if (line_6 !== 3'b000) begin errors++; $display("FAIL reset_line6: got %0b want 000", line_6); end
  endtask

  task automatic test_empty_sweep;
    run_sweep("empty", 1'b0, -1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (draw_done !== 1'b1 || plot !== 1'b0) begin
        errors++;
        $display("FAIL hold_done_%0d: got done=%0b plot=%0b want done=1 plot=0", k, draw_done, plot);
      end
    end
    draw_go = 0;
    @(negedge clock);
    checks++;
    if (draw_done !== 1'b0) begin errors++; $display("FAIL done_release: got %0b want 0", draw_done); end
  endtask

  task automatic test_edge_shift;
    logic [2:0] exp_row;
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(1, 20)) @(negedge clock);
      offset_increase = 1;
      repeat (3) @(negedge clock);
      offset_increase = 0;
      exp_row = row_of(m_lfsr);
      edge_go = 1;
      repeat (6) @(negedge clock);
      edge_go = 0;
      checks++;
      if (line_6 !== exp_row) begin
        errors++;
        $display("FAIL edge_shift_%0d: line_6 got %0b want %0b", it, line_6, exp_row);
      end
      checks++;
      if (offset !== 6'd0) begin
        errors++;
        $display("FAIL edge_offset_%0d: got %0d want 0", it, offset);
      end
    end
  endtask

  task automatic test_offset;
    @(negedge clock);
    board_clear = 1;
    @(negedge clock);
    board_clear = 0;
    offset_increase = 1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (k == 1 || k == 20 || k >= 40) begin
        checks++;
        if (offset !== 6'((k < 40) ? k : 40)) begin
          errors++;
          $display("FAIL offset_sat_%0d: got %0d want %0d", k, offset, (k < 40) ? k : 40);
        end
      end
    end
    offset_increase = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (offset !== 6'd40) begin errors++; $display("FAIL offset_hold: got %0d want 40", offset); end
    edge_go = 1; offset_increase = 1;
    @(negedge clock);
    edge_go = 0; offset_increase = 0;
    checks++;
    if (offset !== 6'd0) begin errors++; $display("FAIL offset_coincide: got %0d want 0", offset); end
    offset_increase = 1;
    repeat (5) @(negedge clock);
    board_clear = 1; edge_go = 1;
    repeat (2) @(negedge clock);
    board_clear = 0; edge_go = 0; offset_increase = 0;
    checks++;
    if (offset !== 6'd0 || line_6 !== 3'b000) begin
      errors++;
      $display("FAIL clear_override: got offset=%0d line_6=%0b want 0 000", offset, line_6);
    end
  endtask

  task automatic test_random_board;
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (offset !== 6'(m_off) || line_6 !== m_line[6]) bad++;
      board_clear = ($urandom_range(0, 99) < 3);
      edge_go = ($urandom_range(0, 99) < 15);
      offset_increase = ($urandom_range(0, 99) < 40);
    end
    @(negedge clock);
    board_clear = 0; edge_go = 0; offset_increase = 0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_board: %0d cycles differ, want 0", bad); end
  endtask

  task automatic test_pattern_sweep;
    int n;
    @(negedge clock);
    board_clear = 1;
    @(negedge clock);
    board_clear = 0;
    edge_go = 1;
    n = 0;
    while (m_line[6] !== 3'b001 && n < 300) begin
      @(negedge clock);
      n++;
    end
    edge_go = 0;
    checks++;
    if (line_6 !== 3'b001) begin
      errors++;
      $display("FAIL pattern_setup: line_6 got %0b want 001 after %0d shifts", line_6, n);
    end
    offset_increase = 1;
    repeat (40) @(negedge clock);
    offset_increase = 0;
    checks++;
    if (offset !== 6'd40) begin errors++; $display("FAIL pattern_offset: got %0d want 40", offset); end
    run_sweep("pattern", 1'b1, -1);
    @(negedge clock);
    checks++;
    if (draw_done !== 1'b0) begin errors++; $display("FAIL pattern_done_drop: got %0b want 0", draw_done); end
  endtask

  task automatic test_reset_abort;
    run_sweep("abort", 1'b0, 5000);
    @(negedge clock);
    resetn = 1;
    repeat (3) @(negedge clock);
    checks++;
    if (plot !== 1'b0 || draw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got plot=%0b done=%0b want 0 0", plot, draw_done);
    end
    run_sweep("restart", 1'b0, -1);
    draw_go = 0;
    @(negedge clock);
    checks++;
    if (draw_done !== 1'b0) begin errors++; $display("FAIL restart_release: got %0b want 0", draw_done); end
  endtask

  initial begin
    test_reset;
    test_empty_sweep;
    test_edge_shift;
    test_offset;
    test_random_board;
    test_pattern_sweep;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
